// File: rtl/trap_sequencer_if.sv
// Signal bundle between the commit stage, the trap sequencer and the CSR unit's trap port.
// The master side is the sequencer; the slave side is the surrounding core/CSR environment.
interface trap_sequencer_if #(
  parameter int EXC_W = 5
);
  logic             instr_valid;
  logic [31:0]      instr_pc;
  logic [31:0]      instr_next_pc;
  logic             exc_req;
  logic [EXC_W-1:0] exc_code;
  logic [31:0]      exc_val;
  logic             mret_req;
  logic             wfi_req;
  logic             irq_pending;
  logic [31:0]      irq_cause;
  logic             irq_wake;
  logic [31:0]      trap_vector;
  logic [31:0]      epc_in;
  logic             trap_entry;
  logic             trap_return;
  logic [31:0]      trap_pc;
  logic [31:0]      trap_cause;
  logic [31:0]      trap_val;
  logic             instr_retired;
  logic             stall;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;

  modport master (
    input  instr_valid, instr_pc, instr_next_pc, exc_req, exc_code, exc_val,
           mret_req, wfi_req, irq_pending, irq_cause, irq_wake, trap_vector, epc_in,
    output trap_entry, trap_return, trap_pc, trap_cause, trap_val,
           instr_retired, stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    output instr_valid, instr_pc, instr_next_pc, exc_req, exc_code, exc_val,
           mret_req, wfi_req, irq_pending, irq_cause, irq_wake, trap_vector, epc_in,
    input  trap_entry, trap_return, trap_pc, trap_cause, trap_val,
           instr_retired, stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_sequencer.sv
// Sequences exception/interrupt entry, MRET return and WFI sleep toward the CSR unit,
// then redirects and flushes the pipeline.
module trap_sequencer #(
  parameter bit WFI_EN = 1'b1,
  parameter int EXC_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  trap_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTER    = 3'd1,
    ST_RET      = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_SLEEP    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_cause_q, trap_cause_d;
  logic [31:0] trap_val_q, trap_val_d;
  logic [31:0] wake_pc_q, wake_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        trap_entry_q, trap_return_q, redirect_valid_q, flush_q;
  logic        instr_retired_s, stall_s;

  // Next-state, capture and commit-handshake decode
  always_comb begin
    state_d         = state_q;
    trap_pc_d       = trap_pc_q;
    trap_cause_d    = trap_cause_q;
    trap_val_d      = trap_val_q;
    wake_pc_d       = wake_pc_q;
    redirect_pc_d   = redirect_pc_q;
    instr_retired_s = 1'b0;
    stall_s         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        stall_s = 1'b0;
        if (bus.instr_valid) begin
          if (bus.exc_req) begin
            stall_s      = 1'b1;
            trap_pc_d    = bus.instr_pc;
            trap_cause_d = {{(32-EXC_W){1'b0}}, bus.exc_code};
            trap_val_d   = bus.exc_val;
            state_d      = ST_ENTER;
          end else if (bus.irq_pending) begin
            // The interrupted instruction completes, so mepc points past it
            stall_s         = 1'b1;
            instr_retired_s = 1'b1;
            trap_pc_d       = bus.instr_next_pc;
            trap_cause_d    = bus.irq_cause;
            trap_val_d      = 32'd0;
            state_d         = ST_ENTER;
          end else if (bus.mret_req) begin
            stall_s         = 1'b1;
            instr_retired_s = 1'b1;
            state_d         = ST_RET;
          end else if (bus.wfi_req && WFI_EN) begin
            stall_s         = 1'b1;
            instr_retired_s = 1'b1;
            wake_pc_d       = bus.instr_next_pc;
            state_d         = ST_SLEEP;
          end else begin
            instr_retired_s = 1'b1;
          end
        end else begin
          instr_retired_s = 1'b0;
        end
      end
      ST_ENTER: begin
        redirect_pc_d = bus.trap_vector;
        state_d       = ST_REDIRECT;
      end
      ST_RET: begin
        redirect_pc_d = bus.epc_in;
        state_d       = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      ST_SLEEP: begin
        if (bus.irq_wake && bus.irq_pending) begin
          trap_pc_d    = wake_pc_q;
          trap_cause_d = bus.irq_cause;
          trap_val_d   = 32'd0;
          state_d      = ST_ENTER;
        end else if (bus.irq_wake) begin
          // Wake with MIE clear: the next PC is already in fetch, no redirect
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SLEEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, captured trap data and registered strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      trap_pc_q        <= 32'd0;
      trap_cause_q     <= 32'd0;
      trap_val_q       <= 32'd0;
      wake_pc_q        <= 32'd0;
      redirect_pc_q    <= 32'd0;
      trap_entry_q     <= 1'b0;
      trap_return_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      trap_pc_q        <= trap_pc_d;
      trap_cause_q     <= trap_cause_d;
      trap_val_q       <= trap_val_d;
      wake_pc_q        <= wake_pc_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_entry_q     <= (state_d == ST_ENTER);
      trap_return_q    <= (state_d == ST_RET);
      redirect_valid_q <= (state_d == ST_REDIRECT);
      flush_q          <= (state_d == ST_REDIRECT);
    end
  end

  assign bus.trap_entry     = trap_entry_q;
  assign bus.trap_return    = trap_return_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.trap_cause     = trap_cause_q;
  assign bus.trap_val       = trap_val_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_pc_q;
  // Held in reset, the commit handshake must not accept anything
  assign bus.instr_retired  = rst_n & instr_retired_s;
  assign bus.stall          = rst_n & stall_s;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed and randomized bench for trap_sequencer; the random phase is checked against
// a transaction-level model that queues the expected strobe sequence per accepted request.
module tb_trap_sequencer;
  localparam logic [31:0] VEC_BASE = 32'h0000_0200;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  trap_sequencer_if #(.EXC_W(5)) bus();
  trap_sequencer #(.WFI_EN(1'b1), .EXC_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // CSR unit vector table: vectored mode for interrupts, base for exceptions
  function automatic logic [31:0] vec_of(input logic [31:0] cause);
    return cause[31] ? (VEC_BASE + {cause[29:0], 2'b00}) : VEC_BASE;
  endfunction
  assign bus.trap_vector = vec_of(bus.trap_cause);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.instr_valid = 1'b0; bus.instr_pc = 32'd0; bus.instr_next_pc = 32'd0;
    bus.exc_req = 1'b0; bus.exc_code = 5'd0; bus.exc_val = 32'd0;
    bus.mret_req = 1'b0; bus.wfi_req = 1'b0; bus.irq_pending = 1'b0;
    bus.irq_cause = 32'd0; bus.irq_wake = 1'b0; bus.epc_in = 32'd0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    next_cycle(); next_cycle(); #1;
    checks++; if ({bus.trap_entry, bus.trap_return, bus.instr_retired, bus.stall, bus.flush, bus.redirect_valid} !== 6'b0) begin failures++; $display("FAIL reset_strobes: got %b want 000000", {bus.trap_entry, bus.trap_return, bus.instr_retired, bus.stall, bus.flush, bus.redirect_valid}); end
    checks++; if ({bus.trap_pc, bus.trap_cause, bus.trap_val, bus.redirect_pc} !== 128'd0) begin failures++; $display("FAIL reset_data: got %h want 0", {bus.trap_pc, bus.trap_cause, bus.trap_val, bus.redirect_pc}); end
    next_cycle(); rst_n = 1'b1;
  endtask

  task automatic test_exception();
    next_cycle();
    bus.instr_valid = 1'b1; bus.exc_req = 1'b1; bus.exc_code = 5'd2;
    bus.instr_pc = 32'h100; bus.instr_next_pc = 32'h104; bus.exc_val = 32'hDEADBEEF; #1;
    checks++; if ({bus.instr_retired, bus.stall} !== 2'b01) begin failures++; $display("FAIL exc_accept: got retired,stall=%b want 01", {bus.instr_retired, bus.stall}); end
    next_cycle(); idle_inputs(); #1;
    checks++; if ({bus.trap_entry, bus.trap_return, bus.redirect_valid, bus.stall} !== 4'b1001) begin failures++; $display("FAIL exc_entry_strobes: got %b want 1001", {bus.trap_entry, bus.trap_return, bus.redirect_valid, bus.stall}); end
    checks++; if ({bus.trap_pc, bus.trap_cause, bus.trap_val} !== {32'h100, 32'h2, 32'hDEADBEEF}) begin failures++; $display("FAIL exc_entry_data: got %h %h %h want 100 2 deadbeef", bus.trap_pc, bus.trap_cause, bus.trap_val); end
    next_cycle(); #1;
    checks++; if ({bus.redirect_valid, bus.flush, bus.trap_entry, bus.instr_retired} !== 4'b1100) begin failures++; $display("FAIL exc_redirect_strobes: got %b want 1100", {bus.redirect_valid, bus.flush, bus.trap_entry, bus.instr_retired}); end
    checks++; if (bus.redirect_pc !== 32'h200) begin failures++; $display("FAIL exc_redirect_pc: got %h want 200", bus.redirect_pc); end
    next_cycle(); #1;
    checks++; if ({bus.redirect_valid, bus.stall, bus.redirect_pc, bus.trap_pc} !== {2'b00, 32'h200, 32'h100}) begin failures++; $display("FAIL exc_hold: got rv,stall=%b rpc=%h pc=%h", {bus.redirect_valid, bus.stall}, bus.redirect_pc, bus.trap_pc); end
  endtask

  task automatic test_interrupt();
    next_cycle();
    bus.instr_valid = 1'b1; bus.irq_pending = 1'b1; bus.irq_cause = 32'h8000000B;
    bus.instr_pc = 32'h40; bus.instr_next_pc = 32'h44; #1;
    checks++; if ({bus.instr_retired, bus.stall} !== 2'b11) begin failures++; $display("FAIL irq_accept: got %b want 11", {bus.instr_retired, bus.stall}); end
    next_cycle(); idle_inputs(); #1;
    checks++; if ({bus.trap_entry, bus.trap_pc, bus.trap_cause, bus.trap_val} !== {1'b1, 32'h44, 32'h8000000B, 32'h0}) begin failures++; $display("FAIL irq_entry: got te=%b %h %h %h", bus.trap_entry, bus.trap_pc, bus.trap_cause, bus.trap_val); end
    next_cycle(); #1;
    checks++; if ({bus.redirect_valid, bus.flush, bus.redirect_pc} !== {2'b11, 32'h22C}) begin failures++; $display("FAIL irq_redirect: got %b %h want 11 22c", {bus.redirect_valid, bus.flush}, bus.redirect_pc); end
  endtask

  task automatic test_mret();
    int stall_cnt = 0;
    int ret_cnt = 0;
    int entry_cnt = 0;
    next_cycle(); idle_inputs();
    bus.instr_valid = 1'b1; bus.mret_req = 1'b1; bus.epc_in = 32'h44; #1;
    checks++; if (bus.instr_retired !== 1'b1) begin failures++; $display("FAIL mret_retire: got %b want 1", bus.instr_retired); end
    for (int i = 0; i < 5; i++) begin
      stall_cnt += int'(bus.stall); ret_cnt += int'(bus.trap_return); entry_cnt += int'(bus.trap_entry);
      if (i == 2) begin
        checks++; if ({bus.redirect_valid, bus.flush, bus.redirect_pc} !== {2'b11, 32'h44}) begin failures++; $display("FAIL mret_redirect: got %b %h want 11 44", {bus.redirect_valid, bus.flush}, bus.redirect_pc); end
      end
      next_cycle(); bus.instr_valid = 1'b0; bus.mret_req = 1'b0; #1;
    end
    checks++; if ({stall_cnt, ret_cnt, entry_cnt} !== {32'd3, 32'd1, 32'd0}) begin failures++; $display("FAIL mret_counts: got stall=%0d ret=%0d entry=%0d want 3 1 0", stall_cnt, ret_cnt, entry_cnt); end
  endtask

  task automatic test_priority();
    int ret_cnt = 0;
    int entry_cnt = 0;
    next_cycle(); idle_inputs();
    bus.instr_valid = 1'b1; bus.exc_req = 1'b1; bus.irq_pending = 1'b1; bus.mret_req = 1'b1;
    bus.exc_code = 5'd5; bus.irq_cause = 32'h80000003; bus.instr_pc = 32'h300; bus.epc_in = 32'h999; #1;
    checks++; if (bus.instr_retired !== 1'b0) begin failures++; $display("FAIL prio_retire: got %b want 0", bus.instr_retired); end
    for (int i = 0; i < 4; i++) begin
      next_cycle(); idle_inputs(); #1;
      ret_cnt += int'(bus.trap_return); entry_cnt += int'(bus.trap_entry);
      if (i == 0) begin
        checks++; if ({bus.trap_cause, bus.trap_pc} !== {32'h5, 32'h300}) begin failures++; $display("FAIL prio_cause: got %h %h want 5 300", bus.trap_cause, bus.trap_pc); end
      end
    end
    checks++; if ({ret_cnt, entry_cnt} !== {32'd0, 32'd1}) begin failures++; $display("FAIL prio_counts: got ret=%0d entry=%0d want 0 1", ret_cnt, entry_cnt); end
  endtask

  task automatic test_wfi();
    int stall_cnt = 0;
    int strobe_cnt = 0;
    next_cycle(); idle_inputs();
    bus.instr_valid = 1'b1; bus.wfi_req = 1'b1; bus.instr_next_pc = 32'h80; #1;
    checks++; if ({bus.instr_retired, bus.stall} !== 2'b11) begin failures++; $display("FAIL wfi_accept: got %b want 11", {bus.instr_retired, bus.stall}); end
    for (int i = 0; i < 20; i++) begin
      next_cycle(); idle_inputs();
      bus.instr_valid = 1'($urandom); bus.exc_req = 1'($urandom); bus.mret_req = 1'($urandom);
      bus.irq_pending = 1'($urandom); bus.instr_pc = $urandom; #1;
      stall_cnt += int'(bus.stall);
      strobe_cnt += int'(bus.trap_entry) + int'(bus.trap_return) + int'(bus.redirect_valid) + int'(bus.instr_retired);
    end
    checks++; if ({stall_cnt, strobe_cnt} !== {32'd20, 32'd0}) begin failures++; $display("FAIL wfi_sleep: got stall=%0d strobes=%0d want 20 0", stall_cnt, strobe_cnt); end
    next_cycle(); idle_inputs(); bus.irq_wake = 1'b1; bus.irq_pending = 1'b1; bus.irq_cause = 32'h80000007; #1;
    next_cycle(); idle_inputs(); #1;
    checks++; if ({bus.trap_entry, bus.trap_pc, bus.trap_cause, bus.trap_val} !== {1'b1, 32'h80, 32'h80000007, 32'h0}) begin failures++; $display("FAIL wfi_wake_entry: got te=%b %h %h %h", bus.trap_entry, bus.trap_pc, bus.trap_cause, bus.trap_val); end
    next_cycle(); #1;
    checks++; if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h21C}) begin failures++; $display("FAIL wfi_wake_redirect: got %b %h want 1 21c", bus.redirect_valid, bus.redirect_pc); end
    next_cycle(); bus.instr_valid = 1'b1; bus.wfi_req = 1'b1; bus.instr_next_pc = 32'h90; #1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle_inputs(); #1;
    end
    next_cycle(); bus.irq_wake = 1'b1; bus.irq_pending = 1'b0; #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL wfi_nomie_wake_stall: got %b want 1", bus.stall); end
    strobe_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle_inputs(); #1;
      strobe_cnt += int'(bus.trap_entry) + int'(bus.redirect_valid) + int'(bus.stall);
    end
    checks++; if ({strobe_cnt, bus.trap_pc} !== {32'd0, 32'h80}) begin failures++; $display("FAIL wfi_nomie_idle: got strobes=%0d pc=%h want 0 80", strobe_cnt, bus.trap_pc); end
  endtask

  task automatic test_reset_mid();
    next_cycle(); idle_inputs();
    bus.instr_valid = 1'b1; bus.exc_req = 1'b1; bus.exc_code = 5'd7; bus.instr_pc = 32'h500; bus.exc_val = 32'h1234; #1;
    next_cycle(); idle_inputs(); rst_n = 1'b0; #1;
    checks++; if (bus.trap_entry !== 1'b1) begin failures++; $display("FAIL rstmid_enter: got %b want 1", bus.trap_entry); end
    next_cycle(); rst_n = 1'b1; #1;
    checks++; if ({bus.trap_entry, bus.trap_return, bus.redirect_valid, bus.flush, bus.stall, bus.instr_retired, bus.trap_pc, bus.trap_cause, bus.trap_val, bus.redirect_pc} !== 134'd0) begin failures++; $display("FAIL rstmid_outputs: got te=%b rv=%b stall=%b pc=%h cause=%h rpc=%h want 0", bus.trap_entry, bus.redirect_valid, bus.stall, bus.trap_pc, bus.trap_cause, bus.redirect_pc); end
    next_cycle(); #1;
    checks++; if ({bus.redirect_valid, bus.flush, bus.trap_entry} !== 3'b000) begin failures++; $display("FAIL rstmid_no_redirect: got %b want 000", {bus.redirect_valid, bus.flush, bus.trap_entry}); end
  endtask

  typedef struct {bit te; bit tr; bit rv;} step_t;

  task automatic test_random();
    step_t       exp_q[$];
    step_t       s;
    bit          m_sleep = 1'b0;
    logic [31:0] m_pc = 32'd0, m_cause = 32'd0, m_val = 32'd0, m_rpc = 32'd0, m_wpc = 32'd0;
    logic [31:0] n_pc, n_cause, n_val, n_rpc, n_wpc;
    bit          e_te, e_tr, e_rv, e_stall, e_ret;
    next_cycle(); idle_inputs(); rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cycle();
      bus.instr_valid = ($urandom_range(0, 9) < 7);
      bus.exc_req = ($urandom_range(0, 9) == 0); bus.irq_pending = ($urandom_range(0, 9) < 2);
      bus.mret_req = ($urandom_range(0, 9) == 0); bus.wfi_req = ($urandom_range(0, 9) == 0);
      bus.irq_wake = ($urandom_range(0, 4) == 0);
      bus.exc_code = 5'($urandom); bus.exc_val = $urandom; bus.instr_pc = $urandom;
      bus.instr_next_pc = $urandom; bus.irq_cause = $urandom; bus.epc_in = $urandom; #1;
      n_pc = m_pc; n_cause = m_cause; n_val = m_val; n_rpc = m_rpc; n_wpc = m_wpc;
      e_te = 1'b0; e_tr = 1'b0; e_rv = 1'b0; e_stall = 1'b0; e_ret = 1'b0;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        e_te = s.te; e_tr = s.tr; e_rv = s.rv; e_stall = 1'b1;
        if (s.te) n_rpc = vec_of(m_cause);
        if (s.tr) n_rpc = bus.epc_in;
      end else if (m_sleep) begin
        e_stall = 1'b1;
        if (bus.irq_wake) begin
          m_sleep = 1'b0;
          if (bus.irq_pending) begin
            n_pc = m_wpc; n_cause = bus.irq_cause; n_val = 32'd0;
            exp_q.push_back('{1'b1, 1'b0, 1'b0}); exp_q.push_back('{1'b0, 1'b0, 1'b1});
          end
        end
      end else if (bus.instr_valid) begin
        e_ret = !bus.exc_req;
        e_stall = bus.exc_req | bus.irq_pending | bus.mret_req | bus.wfi_req;
        if (bus.exc_req) begin
          n_pc = bus.instr_pc; n_cause = {27'd0, bus.exc_code}; n_val = bus.exc_val;
          exp_q.push_back('{1'b1, 1'b0, 1'b0}); exp_q.push_back('{1'b0, 1'b0, 1'b1});
        end else if (bus.irq_pending) begin
          n_pc = bus.instr_next_pc; n_cause = bus.irq_cause; n_val = 32'd0;
          exp_q.push_back('{1'b1, 1'b0, 1'b0}); exp_q.push_back('{1'b0, 1'b0, 1'b1});
        end else if (bus.mret_req) begin
          exp_q.push_back('{1'b0, 1'b1, 1'b0}); exp_q.push_back('{1'b0, 1'b0, 1'b1});
        end else if (bus.wfi_req) begin
          m_sleep = 1'b1; n_wpc = bus.instr_next_pc;
        end
      end
      checks++; if ({bus.trap_entry, bus.trap_return, bus.redirect_valid, bus.flush} !== {e_te, e_tr, e_rv, e_rv}) begin failures++; $display("FAIL rand_strobes cyc=%0d: got te,tr,rv,fl=%b want %b", cyc, {bus.trap_entry, bus.trap_return, bus.redirect_valid, bus.flush}, {e_te, e_tr, e_rv, e_rv}); end
      checks++; if ({bus.stall, bus.instr_retired} !== {e_stall, e_ret}) begin failures++; $display("FAIL rand_handshake cyc=%0d: got stall,ret=%b want %b", cyc, {bus.stall, bus.instr_retired}, {e_stall, e_ret}); end
      checks++; if ({bus.trap_pc, bus.trap_cause, bus.trap_val, bus.redirect_pc} !== {m_pc, m_cause, m_val, m_rpc}) begin failures++; $display("FAIL rand_data cyc=%0d: got %h %h %h %h want %h %h %h %h", cyc, bus.trap_pc, bus.trap_cause, bus.trap_val, bus.redirect_pc, m_pc, m_cause, m_val, m_rpc); end
      m_pc = n_pc; m_cause = n_cause; m_val = n_val; m_rpc = n_rpc; m_wpc = n_wpc;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_exception();
    test_interrupt();
    test_mret();
    test_priority();
    test_wfi();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Core-side initiator for the CSR unit's trap interface: sequences exception entry, interrupt entry, MRET return and WFI sleep.
- Drives the one-cycle trap_entry/trap_return strobes with trap_pc, trap_cause and trap_val, then redirects and flushes the pipeline.
- Sits between the commit stage and the CSR unit; consumes the CSR unit's interrupt_pending, interrupt_cause, trap_vector and epc_out.

Parameters:
WFI_EN, 1, 1 = WFI sleeps until wake; 0 = WFI retires as a NOP.
EXC_W, 5, width of the exception code input.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous, active-low reset
instr_valid  input  1  instruction at commit this cycle
instr_pc  input  32  PC of the committing instruction
instr_next_pc  input  32  sequential or branch-resolved next PC of the committing instruction
exc_req  input  1  committing instruction raised an exception
exc_code  input  EXC_W  exception cause code
exc_val  input  32  bad address or instruction for mtval
mret_req  input  1  committing instruction is MRET
wfi_req  input  1  committing instruction is WFI
irq_pending  input  1  from CSR unit interrupt_pending (already gated by MIE)
irq_cause  input  32  from CSR unit interrupt_cause
irq_wake  input  1  OR of mip&mie, not gated by MIE (WFI wake)
trap_vector  input  32  from CSR unit, combinational on trap_cause
epc_in  input  32  from CSR unit epc_out
trap_entry  output  1  one-cycle strobe to CSR unit
trap_return  output  1  one-cycle strobe to CSR unit
trap_pc  output  32  registered PC to save in mepc
trap_cause  output  32  registered cause
trap_val  output  32  registered trap value
instr_retired  output  1  commit accepted without exception
stall  output  1  freeze fetch and commit
flush  output  1  kill in-flight instructions
redirect_valid  output  1  load redirect_pc into the PC
redirect_pc  output  32  new PC

Behaviour:
- Reset (sync, active-low):
  - State IDLE.
  - All outputs and internal registers 0.
  - Reset mid-sequence abandons the sequence; no strobe is emitted in the cycle after reset.
- States: IDLE, ENTER, RET, REDIRECT, SLEEP.
- IDLE acceptance, evaluated only when instr_valid=1. Priority, highest first:
  1. exc_req: capture trap_pc=instr_pc, trap_cause={0,exc_code}, trap_val=exc_val; go to ENTER; instr_retired=0.
  2. irq_pending: instruction retires (instr_retired=1); capture trap_pc=instr_next_pc, trap_cause=irq_cause, trap_val=0; go to ENTER.
  3. mret_req: instr_retired=1; go to RET.
  4. wfi_req with WFI_EN=1: instr_retired=1; capture instr_next_pc; go to SLEEP.
  5. Otherwise: instr_retired=1; stay in IDLE.
- instr_retired is 0 when instr_valid=0 or state≠IDLE.
- ENTER (1 cycle):
  - trap_entry=1; trap_pc, trap_cause and trap_val stable.
  - Capture trap_vector into redirect_pc; go to REDIRECT.
- RET (1 cycle):
  - trap_return=1.
  - Capture epc_in into redirect_pc (mepc is stable; the CSR unit updates only mstatus on return); go to REDIRECT.
- REDIRECT (1 cycle): redirect_valid=1, flush=1; go to IDLE.
- SLEEP:
  - Stay while irq_wake=0.
  - On irq_wake=1 with irq_pending=1: load trap_pc=captured next PC, trap_cause=irq_cause, trap_val=0; go to ENTER.
  - On irq_wake=1 with irq_pending=0 (MIE=0): go to IDLE without redirect; execution resumes at the already-fetched next PC.
- stall = (state≠IDLE) OR (IDLE AND instr_valid AND (exc_req OR irq_pending OR mret_req OR (wfi_req AND WFI_EN))).
- Latency:
  - Exception or interrupt accepted in cycle N: trap_entry in N+1, redirect_valid in N+2, first handler fetch in N+3.
  - MRET follows the same timing.
- All request inputs are ignored when state≠IDLE.
- trap_entry and trap_return are never high in the same cycle.
- Simultaneous exc_req and mret_req: the exception wins and no trap_return is issued.
- trap_pc, trap_cause and trap_val hold their last values until the next capture.
- redirect_pc holds after REDIRECT.

Test Plan:
- Exception: instr_valid=1, exc_req=1, exc_code=2, instr_pc=0x100, exc_val=0xDEADBEEF, trap_vector=0x200 -> next cycle trap_entry=1, trap_pc=0x100, trap_cause=0x2, trap_val=0xDEADBEEF; following cycle redirect_valid=1, flush=1, redirect_pc=0x200; instr_retired=0 throughout.
- Interrupt: irq_pending=1, irq_cause=0x8000000B, instr_valid=1, instr_next_pc=0x44 -> instr_retired=1; trap_pc=0x44, trap_cause=0x8000000B, trap_val=0; redirect_pc=trap_vector (vectored 0x2C+base).
- MRET: mret_req=1, epc_in=0x44 -> trap_return pulses for exactly 1 cycle, then redirect_pc=0x44 with flush=1; stall high for 3 cycles total.
- Priority: exc_req, irq_pending and mret_req all 1 -> only the exception sequence runs, trap_cause=exc_code, no trap_return.
- WFI:
  - wfi_req at instr_next_pc=0x80; stall holds 20 cycles with irq_wake=0.
  - irq_wake=1, irq_pending=1 -> trap_entry with trap_pc=0x80.
  - Repeat with irq_pending=0 -> state returns to IDLE, no trap_entry, no redirect.
- Reset mid-sequence: assert rst_n=0 in the ENTER cycle -> next cycle all outputs 0, state IDLE; no redirect follows.
